// File: rtl/alu_16.sv
// rtl/alu_16.sv - 16-bit registered integer ALU with z/v/n flags
//
// Purpose:
//   Execute-stage ALU. One of eight arithmetic/logic/shift operations is
//   selected by alu_op and applied to alu_a/alu_b. The result and its zero,
//   signed-overflow and negative flags are captured together on every rising
//   clock edge, giving one op per cycle with one cycle of latency.
//
// Ports:
//   clk      in   1      single clock, all state on rising edge
//   rst      in   1      synchronous, active-high reset
//   alu_op   in   3      operation select (`ALU_* encodings)
//   alu_a    in   WIDTH  operand A
//   alu_b    in   WIDTH  operand B (shift amount = alu_b[3:0] for shifts)
//   alu_out  out  WIDTH  registered result
//   z        out  1      registered zero flag
//   v        out  1      registered signed-overflow flag
//   n        out  1      registered negative flag

`ifndef ALU_ADD
`define ALU_ADD  3'b000
`endif
`ifndef ALU_SUB
`define ALU_SUB  3'b001
`endif
`ifndef ALU_AND
`define ALU_AND  3'b010
`endif
`ifndef ALU_OR
`define ALU_OR   3'b011
`endif
`ifndef ALU_XOR
`define ALU_XOR  3'b100
`endif
`ifndef ALU_NAND
`define ALU_NAND 3'b101
`endif
`ifndef ALU_SHL
`define ALU_SHL  3'b110
`endif
`ifndef ALU_SHR
`define ALU_SHR  3'b111
`endif

module alu_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             v,
  output logic             n
);

  // Shift amount uses only the low log2(WIDTH) bits of B; upper bits ignored.
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] result;
  logic             result_v;

  assign sum   = alu_a + alu_b;   // carry-out intentionally discarded
  assign diff  = alu_a - alu_b;
  assign shamt = alu_b[SHW-1:0];

  // Signed overflow: ADD overflows when like-signed operands give a result of
  // the other sign; SUB when unlike-signed operands give a result whose sign
  // differs from A.
  assign add_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1]  != alu_a[WIDTH-1]);
  assign sub_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);

  always_comb begin
    result   = '0;
    result_v = 1'b0;
    case (alu_op)
      `ALU_ADD: begin
        result   = sum;
        result_v = add_ovf;
      end
      `ALU_SUB: begin
        result   = diff;
        result_v = sub_ovf;
      end
      `ALU_AND:  result = alu_a & alu_b;
      `ALU_OR:   result = alu_a | alu_b;
      `ALU_XOR:  result = alu_a ^ alu_b;
      `ALU_NAND: result = ~(alu_a & alu_b);
      `ALU_SHL:  result = alu_a << shamt;
      `ALU_SHR:  result = alu_a >> shamt;
      default: begin
        result   = '0;
        result_v = 1'b0;
      end
    endcase
  end

  // Result and flags share one register stage so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out <= '0;
      z       <= 1'b1;
      v       <= 1'b0;
      n       <= 1'b0;
    end else begin
      alu_out <= result;
      z       <= (result == '0);
      v       <= result_v;
      n       <= result[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_16.sv
// tb/tb_alu_16.sv - self-checking randomized testbench for alu_16

module tb_alu_16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_SHR  = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        z;
  logic        v;
  logic        n;

  int compared;
  int mismatched;

  alu_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .z       (z),
    .v       (v),
    .n       (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference model from the arithmetic definitions using plain integers.
  task automatic model(input int op, input int a, input int b,
                       output int res, output int ez, output int ev, output int en);
    int s;
    int amt;
    amt = b % 16;
    ev  = 0;
    case (op)
      0: begin
        s   = to_signed(a) + to_signed(b);
        ev  = (s > 32767 || s < -32768) ? 1 : 0;
        res = (a + b) % 65536;
      end
      1: begin
        s   = to_signed(a) - to_signed(b);
        ev  = (s > 32767 || s < -32768) ? 1 : 0;
        res = (a - b + 65536) % 65536;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 65535 - (a & b);
      6: res = (a * (1 << amt)) % 65536;
      default: res = a / (1 << amt);
    endcase
    ez = (res == 0) ? 1 : 0;
    en = (res >= 32768) ? 1 : 0;
  endtask

  task automatic check_outputs(input string tag, input int res, input int ez,
                               input int ev, input int en);
    check({tag, ".out"}, int'(alu_out), res);
    check({tag, ".z"},   int'(z),       ez);
    check({tag, ".v"},   int'(v),       ev);
    check({tag, ".n"},   int'(n),       en);
  endtask

  // Called at a negedge: drive one op, wait one cycle, check at next negedge.
  task automatic step(input string tag, input logic [2:0] op,
                      input logic [15:0] a, input logic [15:0] b);
    int res, ez, ev, en;
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    model(int'(op), int'(a), int'(b), res, ez, ev, en);
    @(negedge clk);
    check_outputs(tag, res, ez, ev, en);
  endtask

  task automatic step_reset(input string tag);
    rst    = 1'b1;
    alu_op = 3'($urandom_range(0, 7));
    alu_a  = 16'($urandom);
    alu_b  = 16'($urandom);
    @(negedge clk);
    check_outputs(tag, 0, 1, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst    = 1'b1;
    alu_op = OP_ADD;
    alu_a  = 16'h7FFF;
    alu_b  = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 0, 1, 0, 0);
    rst = 1'b0;

    // Directed boundary cases
    step("nand1",  OP_NAND, 16'h0003, 16'h0005);
    check("nand1.val", int'(alu_out), 16'hFFFE);
    step("nand2",  OP_NAND, 16'hFFFF, 16'hFFFF);
    step("add_ov", OP_ADD,  16'h7FFF, 16'h0001);
    check("add_ov.vflag", int'(v), 1);
    step("add_z",  OP_ADD,  16'hFFFF, 16'h0001);
    step("sub_ov", OP_SUB,  16'h8000, 16'h0001);
    check("sub_ov.val", int'(alu_out), 16'h7FFF);
    step("sub_z",  OP_SUB,  16'h0005, 16'h0005);
    step("shl15",  OP_SHL,  16'h0001, 16'h000F);
    step("shr3",   OP_SHR,  16'h8000, 16'h0013);
    check("shr3.val", int'(alu_out), 16'h1000);
    step("and",    OP_AND,  16'hF0F0, 16'h0FF0);
    step("or",     OP_OR,   16'hF000, 16'h000F);
    step("xor",    OP_XOR,  16'hAAAA, 16'hAAAA);
    step("sub_neg",OP_SUB,  16'h0000, 16'h0001);

    // Back-to-back ops, reset mid-stream, then resume
    step("b2b0", OP_ADD, 16'h1234, 16'h1111);
    step("b2b1", OP_XOR, 16'h00FF, 16'h0F0F);
    step_reset("midrst");
    step("resume", OP_SUB, 16'h0010, 16'h0020);

    // Randomized stream with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        step_reset("rand_rst");
      end else begin
        logic [15:0] ra, rb;
        ra = 16'($urandom);
        rb = 16'($urandom);
        case ($urandom_range(0, 3))
          0: ra = 16'h7FFF ^ 16'($urandom_range(0, 3));
          1: rb = 16'h8000 | 16'($urandom_range(0, 3));
          default: ;
        endcase
        step("rand", 3'($urandom_range(0, 7)), ra, rb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
